reset_sequencer: RTL and testbench

Multi-stage reset release sequencer for a single clock domain. It holds every downstream reset asserted until the clock source reports lock for a minimum qualified period. It then releases NUM_STAGES reset outputs one at a time, STAGE_GAP cycles apart. Any later loss of lock or software reset request re-asserts all stages and restarts the sequence.

---
 rtl/reset_sequencer.sv | 117 +++++++++++
 tb/tb_reset_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: wait for a qualified clock lock, then drop reset_out[0..N-1]
// one at a time STAGE_GAP cycles apart; lock loss or soft request restarts the sequence.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  lock_in,
  input  logic                  soft_req_in,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  ready_out,
  output logic [7:0]            restart_count_out
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [NUM_STAGES-1:0]   reset_n;
  logic                    ready_n;
  logic [7:0]              restart_n;
  logic                    lock_meta, lock_sync;
  logic                    restart;

  assign restart = !lock_sync || soft_req_in;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      lock_meta         <= 1'b0;
      lock_sync         <= 1'b0;
      state             <= ASSERT;
      cnt               <= '0;
      idx               <= '0;
      reset_out         <= '1;
      ready_out         <= 1'b0;
      restart_count_out <= 8'd0;
    end else begin
      lock_meta         <= lock_in;
      lock_sync         <= lock_meta;
      state             <= state_n;
      cnt               <= cnt_n;
      idx               <= idx_n;
      reset_out         <= reset_n;
      ready_out         <= ready_n;
      restart_count_out <= restart_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    reset_n   = reset_out;
    ready_n   = ready_out;
    restart_n = restart_count_out;
    case (state)
      ASSERT: begin
        reset_n = '1;
        ready_n = 1'b0;
        if (restart) begin
          cnt_n = '0;
        end else if (cnt == HOLD_LAST) begin
          reset_n[0] = 1'b0;
          cnt_n      = '0;
          idx_n      = IW'(1);
          if (NUM_STAGES == 1) begin
            state_n = RUN;
            ready_n = 1'b1;
          end else begin
            state_n = RELEASE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        // restart wins over a stage release due on the same edge
        if (!restart) begin
          if (cnt == GAP_LAST) begin
            for (int i = 0; i < NUM_STAGES; i++)
              if (idx == IW'(i)) reset_n[i] = 1'b0;
            idx_n = idx + IW'(1);
            cnt_n = '0;
            if (idx == IDX_LAST) begin
              state_n = RUN;
              ready_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      RUN: ;
      default: state_n = ASSERT;
    endcase
    if (state != ASSERT && restart) begin
      state_n   = ASSERT;
      reset_n   = '1;
      ready_n   = 1'b0;
      cnt_n     = '0;
      idx_n     = '0;
      restart_n = (restart_count_out == 8'hFF) ? 8'hFF : restart_count_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default 3-stage instance plus a 1-stage instance, both
// checked every cycle against a timeline model, plus directed schedule checks.
module tb_reset_sequencer;
  localparam int N = 3, H = 16, G = 8;

  logic clk_in = 0, reset_in = 0, lock_in = 0, soft_req_in = 0;
  logic [N-1:0] reset_out;
  logic         ready_out;
  logic [7:0]   restart_count_out;
  logic [0:0]   reset1;
  logic         ready1;
  logic [7:0]   rc1;

  reset_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(H), .STAGE_GAP(G)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .lock_in(lock_in), .soft_req_in(soft_req_in),
    .reset_out(reset_out), .ready_out(ready_out), .restart_count_out(restart_count_out));

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(H), .STAGE_GAP(G)) dut1 (
    .clk_in(clk_in), .reset_in(reset_in), .lock_in(lock_in), .soft_req_in(soft_req_in),
    .reset_out(reset1), .ready_out(ready1), .restart_count_out(rc1));

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: lock seen two edges late; after H qualified edges the sequence
  // is active and stage k is released once t >= k*G edges have passed.
  bit m_l1 = 0, m_l2 = 0, m_act = 0;
  int m_q = 0, m_t = 0, m_rc = 0;

  always @(posedge clk_in or posedge reset_in) begin : model
    bit rcond;
    if (reset_in) begin
      m_l1 = 0; m_l2 = 0; m_act = 0; m_q = 0; m_t = 0; m_rc = 0;
    end else begin
      rcond = !m_l2 || soft_req_in;
      if (!m_act) begin
        if (rcond) m_q = 0;
        else begin
          m_q++;
          if (m_q == H) begin m_act = 1; m_t = 0; end
        end
      end else if (rcond) begin
        m_act = 0; m_q = 0;
        if (m_rc < 255) m_rc++;
      end else if (m_t < 1000) m_t++;
      m_l2 = m_l1;
      m_l1 = lock_in;
    end
  end

  function automatic logic [31:0] exp_rst(input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = !(m_act && m_t >= k * G);
    return v;
  endfunction

  function automatic logic [31:0] exp_rdy(input int n);
    return {31'd0, m_act && m_t >= (n - 1) * G};
  endfunction

  bit chk_en = 0;
  always @(negedge clk_in) if (chk_en) begin
    chk("m_rst3", reset_out, exp_rst(N));
    chk("m_rdy3", ready_out, exp_rdy(N));
    chk("m_rc3", restart_count_out, m_rc);
    chk("m_rst1", reset1, exp_rst(1));
    chk("m_rdy1", ready1, exp_rdy(1));
    chk("m_rc1", rc1, m_rc);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #1 reset_in = 1;
    #1;
    chk("por_rst", reset_out, 3'b111);
    chk("por_rdy", ready_out, 0);
    chk("por_rc", restart_count_out, 0);
    chk_en  = 1;
    lock_in = 1;
    edges(2);
    reset_in = 0;
    // default schedule
    edges(17); chk("e17", reset_out, 3'b111);
    edges(1);  chk("e18", reset_out, 3'b110); chk("e18_rdy", ready_out, 0);
    chk("e18_r1", reset1, 0); chk("e18_rdy1", ready1, 1);
    edges(8);  chk("e26", reset_out, 3'b100);
    edges(8);  chk("e34", reset_out, 3'b000); chk("e34_rdy", ready_out, 1);
    chk("e34_rc", restart_count_out, 0);
    // late lock
    reset_in = 1; lock_in = 0; edges(1); reset_in = 0;
    edges(50); chk("nolock", reset_out, 3'b111);
    lock_in = 1;
    edges(17); chk("late17", reset_out, 3'b111);
    edges(1);  chk("late18", reset_out, 3'b110); chk("late_rc", restart_count_out, 0);
    // one-cycle lock glitch at cnt=10
    reset_in = 1; lock_in = 0; edges(1); reset_in = 0;
    edges(3); lock_in = 1;
    edges(12); lock_in = 0;
    edges(1);  lock_in = 1;
    edges(17); chk("glitch30", reset_out, 3'b111);
    edges(1);  chk("glitch31", reset_out, 3'b110); chk("glitch_rc", restart_count_out, 0);
    // lock falls so the restart lands on the edge stage 1 is due
    edges(5); lock_in = 0;
    edges(2); chk("lf_pre", reset_out, 3'b110);
    edges(1); chk("lf_rst", reset_out, 3'b111); chk("lf_rc", restart_count_out, 1);
    lock_in = 1;
    // soft request in RUN
    edges(40); chk("run_rdy", ready_out, 1);
    soft_req_in = 1;
    edges(1); soft_req_in = 0;
    chk("soft_rst", reset_out, 3'b111); chk("soft_rdy", ready_out, 0);
    chk("soft_rc", restart_count_out, 2);
    edges(15); chk("soft15", reset_out, 3'b111);
    edges(1);  chk("soft16", reset_out, 3'b110);
    // saturation
    repeat (300) begin
      soft_req_in = 1; edges(1); soft_req_in = 0; edges(16);
    end
    chk("sat", restart_count_out, 255);
    // asynchronous reset during RUN
    edges(20); chk("run2_rdy", ready_out, 1);
    #3 reset_in = 1;
    #1;
    chk("ar_rst", reset_out, 3'b111); chk("ar_rdy", ready_out, 0);
    chk("ar_rc", restart_count_out, 0);
    chk("ar_rst1", reset1, 1); chk("ar_rdy1", ready1, 0);
    #2 reset_in = 0;
    edges(17); chk("one17", reset1, 1); chk("one17_rdy", ready1, 0);
    edges(1);  chk("one18", reset1, 0); chk("one18_rdy", ready1, 1);
    // random phase
    repeat (3000) begin
      edges(1);
      if (lock_in) begin if ($urandom_range(79) == 0) lock_in = 0; end
      else if ($urandom_range(9) == 0) lock_in = 1;
      soft_req_in = ($urandom_range(59) == 0);
      if ($urandom_range(399) == 0) begin
        #2 reset_in = 1;
        #1 chk("rnd_ar", reset_out, 3'b111);
        #1 reset_in = 0;
      end
    end
    edges(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
